except_ctrl: RTL and testbench

EXCEPT_CTRL -- requirements
Module: except_ctrl

---
 rtl/except_ctrl_pkg.sv | 55 +++++
 rtl/except_ctrl_prio_enc.sv | 63 ++++++
 rtl/except_ctrl.sv | 140 ++++++++++++++
 tb/tb_except_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/except_ctrl_pkg.sv
// Shared definitions for the commit-stage exception controller: exception
// bit positions, Cause.ExcCode values, FSM encoding and decode result types.
package except_ctrl_pkg;

  // Exception vector bit positions
  localparam int B_INT      = 0;
  localparam int B_ADEL_I   = 1;
  localparam int B_SYS      = 2;
  localparam int B_BP       = 3;
  localparam int B_ERET     = 4;
  localparam int B_RI       = 5;
  localparam int B_OV       = 6;
  localparam int B_TR       = 7;
  localparam int B_ADEL_D   = 8;
  localparam int B_ADES_D   = 9;
  localparam int B_TLBR_I   = 10;
  localparam int B_TLBI_I   = 11;
  localparam int B_TLBR_DR  = 12;
  localparam int B_TLBR_DW  = 13;
  localparam int B_TLBI_DR  = 14;
  localparam int B_TLBI_DW  = 15;
  localparam int B_MOD      = 16;
  localparam int B_CPU1     = 17;
  localparam int B_CPU0     = 18;
  localparam int B_REFETCH  = 31;

  // Cause.ExcCode values
  localparam logic [4:0] EC_INT  = 5'd0;
  localparam logic [4:0] EC_MOD  = 5'd1;
  localparam logic [4:0] EC_TLBL = 5'd2;
  localparam logic [4:0] EC_TLBS = 5'd3;
  localparam logic [4:0] EC_ADEL = 5'd4;
  localparam logic [4:0] EC_ADES = 5'd5;
  localparam logic [4:0] EC_SYS  = 5'd8;
  localparam logic [4:0] EC_BP   = 5'd9;
  localparam logic [4:0] EC_RI   = 5'd10;
  localparam logic [4:0] EC_CPU  = 5'd11;
  localparam logic [4:0] EC_OV   = 5'd12;
  localparam logic [4:0] EC_TR   = 5'd13;

  typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_REDIRECT} state_t;

  typedef enum logic [1:0] {CLS_NONE, CLS_EXC, CLS_ERET, CLS_REFETCH} exc_class_t;

  // Address-error and TLB-class exceptions also load BadVAddr.
  function automatic logic sets_badvaddr(input logic [4:0] code);
    logic r;
    case (code)
      EC_MOD, EC_TLBL, EC_TLBS, EC_ADEL, EC_ADES: r = 1'b1;
      default:                                    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/except_ctrl_prio_enc.sv
// Combinational priority encoder: picks the single highest-priority event
// from the commit-stage exception vector and classifies it.
module except_prio_enc
  import except_ctrl_pkg::*;
(
  input  logic [31:0] vec_i,
  output logic [4:0]  exccode_o,
  output exc_class_t  cls_o,
  output logic        is_refill_o,
  output logic        is_data_side_o
);

  // Bits 30:19 carry no event and are deliberately dropped.
  logic unused_hi;
  assign unused_hi = ^vec_i[30:19];

  // Fixed-priority chain, highest first; only the winner is reported.
  always_comb begin
    exccode_o      = EC_INT;
    cls_o          = CLS_EXC;
    is_refill_o    = 1'b0;
    is_data_side_o = 1'b0;
    if (vec_i[B_INT])                               exccode_o = EC_INT;
    else if (vec_i[B_ADEL_I])                       exccode_o = EC_ADEL;
    else if (vec_i[B_TLBR_I]) begin
      exccode_o   = EC_TLBL;
      is_refill_o = 1'b1;
    end
    else if (vec_i[B_TLBI_I])                       exccode_o = EC_TLBL;
    else if (vec_i[B_CPU0] || vec_i[B_CPU1])        exccode_o = EC_CPU;
    else if (vec_i[B_RI])                           exccode_o = EC_RI;
    else if (vec_i[B_SYS])                          exccode_o = EC_SYS;
    else if (vec_i[B_BP])                           exccode_o = EC_BP;
    else if (vec_i[B_OV])                           exccode_o = EC_OV;
    else if (vec_i[B_TR])                           exccode_o = EC_TR;
    else if (vec_i[B_ADEL_D]) begin
      exccode_o      = EC_ADEL;
      is_data_side_o = 1'b1;
    end
    else if (vec_i[B_ADES_D]) begin
      exccode_o      = EC_ADES;
      is_data_side_o = 1'b1;
    end
    else if (vec_i[B_TLBR_DR] || vec_i[B_TLBI_DR]) begin
      exccode_o      = EC_TLBL;
      is_refill_o    = vec_i[B_TLBR_DR];
      is_data_side_o = 1'b1;
    end
    else if (vec_i[B_TLBR_DW] || vec_i[B_TLBI_DW]) begin
      exccode_o      = EC_TLBS;
      is_refill_o    = vec_i[B_TLBR_DW];
      is_data_side_o = 1'b1;
    end
    else if (vec_i[B_MOD]) begin
      exccode_o      = EC_MOD;
      is_data_side_o = 1'b1;
    end
    else if (vec_i[B_ERET])                         cls_o = CLS_ERET;
    else if (vec_i[B_REFETCH])                      cls_o = CLS_REFETCH;
    else                                            cls_o = CLS_NONE;
  end

endmodule

// File: rtl/except_ctrl.sv
// Commit-stage exception controller: captures a faulting/eret/refetch
// instruction, emits a one-cycle flush + CP0 update, then holds a redirect
// request until fetch accepts it.
module except_ctrl
  import except_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_BASE   = 32'hBFC00000,
  parameter logic [31:0] REFILL_OFS = 32'h200,
  parameter logic [31:0] GEN_OFS    = 32'h380
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_i,
  input  logic [31:0] exception_vector_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] badvaddr_i,
  input  logic        in_delay_slot_i,
  input  logic        exl_i,
  input  logic [31:0] epc_i,
  input  logic        redirect_ready_i,
  output logic        busy_o,
  output logic        flush_o,
  output logic        cp0_we_o,
  output logic [4:0]  exccode_o,
  output logic        bd_o,
  output logic [31:0] epc_o,
  output logic        badvaddr_we_o,
  output logic [31:0] badvaddr_o,
  output logic        eret_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);

  logic [4:0]  enc_code;
  exc_class_t  enc_cls;
  logic        enc_refill;
  logic        enc_data;

  except_prio_enc u_prio (
    .vec_i          (exception_vector_i),
    .exccode_o      (enc_code),
    .cls_o          (enc_cls),
    .is_refill_o    (enc_refill),
    .is_data_side_o (enc_data)
  );

  logic        take_d;
  logic        is_exc_d;
  logic        badv_we_d;
  logic [31:0] tgt_d;
  logic [31:0] epc_d;

  assign take_d    = valid_i && (enc_cls != CLS_NONE);
  assign is_exc_d  = (enc_cls == CLS_EXC);
  assign badv_we_d = is_exc_d && sets_badvaddr(enc_code);
  assign epc_d     = in_delay_slot_i ? (pc_i - 32'd4) : pc_i;

  // Redirect target resolved at capture so REDIRECT just replays a stored value.
  always_comb begin
    tgt_d = EXC_BASE + GEN_OFS;
    case (enc_cls)
      CLS_EXC:     if (enc_refill && !exl_i) tgt_d = EXC_BASE + REFILL_OFS;
      CLS_ERET:    tgt_d = epc_i;
      CLS_REFETCH: tgt_d = pc_i;
      default:     ;
    endcase
  end

  state_t      state_q;
  logic        flush_q, cp0_we_q, bd_q, badv_we_q, eret_q, rvalid_q;
  logic [4:0]  exccode_q;
  logic [31:0] epc_q, badv_q, rpc_q;

  // Control FSM with registered outputs; inputs are only looked at in IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      flush_q   <= 1'b0;
      cp0_we_q  <= 1'b0;
      eret_q    <= 1'b0;
      badv_we_q <= 1'b0;
      rvalid_q  <= 1'b0;
      bd_q      <= 1'b0;
      exccode_q <= '0;
      epc_q     <= '0;
      badv_q    <= '0;
      rpc_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (take_d) begin
            state_q   <= S_COMMIT;
            flush_q   <= 1'b1;
            cp0_we_q  <= is_exc_d;
            eret_q    <= (enc_cls == CLS_ERET);
            badv_we_q <= badv_we_d;
            exccode_q <= is_exc_d ? enc_code : 5'd0;
            bd_q      <= in_delay_slot_i;
            epc_q     <= epc_d;
            badv_q    <= badv_we_d ? (enc_data ? badvaddr_i : pc_i) : 32'd0;
            rpc_q     <= tgt_d;
          end
        end
        S_COMMIT: begin
          state_q   <= S_REDIRECT;
          flush_q   <= 1'b0;
          cp0_we_q  <= 1'b0;
          eret_q    <= 1'b0;
          badv_we_q <= 1'b0;
          rvalid_q  <= 1'b1;
        end
        S_REDIRECT: begin
          if (redirect_ready_i) begin
            state_q   <= S_IDLE;
            rvalid_q  <= 1'b0;
            bd_q      <= 1'b0;
            exccode_q <= '0;
            epc_q     <= '0;
            badv_q    <= '0;
            rpc_q     <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o           = (state_q != S_IDLE);
  assign flush_o          = flush_q;
  assign cp0_we_o         = cp0_we_q;
  assign exccode_o        = exccode_q;
  assign bd_o             = bd_q;
  assign epc_o            = epc_q;
  assign badvaddr_we_o    = badv_we_q;
  assign badvaddr_o       = badv_q;
  assign eret_o           = eret_q;
  assign redirect_valid_o = rvalid_q;
  assign redirect_pc_o    = rpc_q;

endmodule

// File: tb/tb_except_ctrl.sv
// Directed scoreboard bench for except_ctrl.
module tb_except_ctrl;

  localparam int K_EXC = 1, K_ERET = 2, K_REF = 3;

  logic        clk = 1'b0, resetn = 1'b0;
  logic        valid_i = 1'b0, in_delay_slot_i = 1'b0, exl_i = 1'b0;
  logic        redirect_ready_i = 1'b0;
  logic [31:0] exception_vector_i = '0, pc_i = '0, badvaddr_i = '0, epc_i = '0;
  logic        busy_o, flush_o, cp0_we_o, bd_o, badvaddr_we_o, eret_o, redirect_valid_o;
  logic [4:0]  exccode_o;
  logic [31:0] epc_o, badvaddr_o, redirect_pc_o;

  except_ctrl dut (
    .clk(clk), .resetn(resetn), .valid_i(valid_i),
    .exception_vector_i(exception_vector_i), .pc_i(pc_i), .badvaddr_i(badvaddr_i),
    .in_delay_slot_i(in_delay_slot_i), .exl_i(exl_i), .epc_i(epc_i),
    .redirect_ready_i(redirect_ready_i), .busy_o(busy_o), .flush_o(flush_o),
    .cp0_we_o(cp0_we_o), .exccode_o(exccode_o), .bd_o(bd_o), .epc_o(epc_o),
    .badvaddr_we_o(badvaddr_we_o), .badvaddr_o(badvaddr_o), .eret_o(eret_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [4:0]  code;
    logic        bd;
    logic [31:0] epc;
    logic        bwe;
    logic [31:0] badv;
    logic [31:0] rpc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string t);
    chk({t, "_busy"},   busy_o, 0);
    chk({t, "_flush"},  flush_o, 0);
    chk({t, "_cp0we"},  cp0_we_o, 0);
    chk({t, "_eret"},   eret_o, 0);
    chk({t, "_bd"},     bd_o, 0);
    chk({t, "_bwe"},    badvaddr_we_o, 0);
    chk({t, "_rvalid"}, redirect_valid_o, 0);
    chk({t, "_code"},   exccode_o, 0);
    chk({t, "_epc"},    epc_o, 0);
    chk({t, "_badv"},   badvaddr_o, 0);
    chk({t, "_rpc"},    redirect_pc_o, 0);
  endtask

  // Drive one trigger in IDLE, record expectation, advance to the COMMIT cycle.
  task automatic fire(input logic [31:0] vec, input logic [31:0] pc, input logic [31:0] bva,
                      input logic bd, input logic exl, input logic [31:0] epc_in,
                      input int kind, input logic [4:0] code, input logic [31:0] e_epc,
                      input logic bwe, input logic [31:0] e_badv, input logic [31:0] rpc);
    exp_t e;
    valid_i = 1'b1; exception_vector_i = vec; pc_i = pc; badvaddr_i = bva;
    in_delay_slot_i = bd; exl_i = exl; epc_i = epc_in;
    e.kind = kind; e.code = code; e.bd = bd; e.epc = e_epc;
    e.bwe = bwe; e.badv = e_badv; e.rpc = rpc;
    sb.push_back(e);
    @(posedge clk); #1;
    valid_i = 1'b0; exception_vector_i = '0;
  endtask

  // Compare the COMMIT-cycle outputs against the oldest expectation.
  task automatic check_commit(input string t);
    chk({t, "_sbdepth"}, sb.size(), 1);
    if (sb.size() > 0) cur = sb.pop_front();
    chk({t, "_flush"},  flush_o, 1);
    chk({t, "_busy"},   busy_o, 1);
    chk({t, "_rvalid"}, redirect_valid_o, 0);
    chk({t, "_cp0we"},  cp0_we_o, (cur.kind == K_EXC) ? 1 : 0);
    chk({t, "_eret"},   eret_o, (cur.kind == K_ERET) ? 1 : 0);
    chk({t, "_rpc"},    redirect_pc_o, cur.rpc);
    if (cur.kind == K_EXC) begin
      chk({t, "_code"}, exccode_o, cur.code);
      chk({t, "_bd"},   bd_o, cur.bd);
      chk({t, "_epc"},  epc_o, cur.epc);
      chk({t, "_bwe"},  badvaddr_we_o, cur.bwe);
      if (cur.bwe) chk({t, "_badv"}, badvaddr_o, cur.badv);
    end else begin
      chk({t, "_bwe"},  badvaddr_we_o, 0);
    end
  endtask

  // Hold ready low for w REDIRECT cycles, then accept; optionally poke valid_i while busy.
  task automatic run_redirect(input string t, input int w, input bit poke);
    redirect_ready_i = 1'b0;
    for (int i = 0; i < w; i++) begin
      @(posedge clk); #1;
      chk({t, "_rv_hold"}, redirect_valid_o, 1);
      chk({t, "_rpc_hold"}, redirect_pc_o, cur.rpc);
      chk({t, "_busy_hold"}, busy_o, 1);
      chk({t, "_flush_hold"}, flush_o, 0);
      if (poke && i == 0) begin valid_i = 1'b1; exception_vector_i = 32'h4; end
      if (poke && i == 2) begin valid_i = 1'b0; exception_vector_i = '0; end
    end
    @(posedge clk); #1;
    redirect_ready_i = 1'b1;
    chk({t, "_rv_last"}, redirect_valid_o, 1);
    chk({t, "_rpc_last"}, redirect_pc_o, cur.rpc);
    chk({t, "_cp0we_last"}, cp0_we_o, 0);
    @(posedge clk); #1;
    redirect_ready_i = 1'b0;
    chk({t, "_rv_idle"}, redirect_valid_o, 0);
    chk({t, "_busy_idle"}, busy_o, 0);
    @(posedge clk); #1;
    chk({t, "_no_retrig"}, flush_o, 0);
  endtask

  initial begin
    // Reset state
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", busy_o, 0);

    // No trigger: valid low with vector, then valid high with empty vector
    valid_i = 1'b0; exception_vector_i = 32'h4;
    @(posedge clk); #1;
    chk("novalid_flush", flush_o, 0);
    chk("novalid_busy", busy_o, 0);
    valid_i = 1'b1; exception_vector_i = 32'h0;
    @(posedge clk); #1;
    chk("novec_flush", flush_o, 0);
    chk("novec_busy", busy_o, 0);
    valid_i = 1'b0;

    // Syscall
    fire(32'h4, 32'h80001000, 32'h0, 0, 0, 32'h0,
         K_EXC, 5'd8, 32'h80001000, 0, 32'h0, 32'hBFC00380);
    check_commit("sys");
    run_redirect("sys", 0, 0);

    // Int + Ov: interrupt wins
    fire(32'h41, 32'h80001100, 32'h0, 0, 0, 32'h0,
         K_EXC, 5'd0, 32'h80001100, 0, 32'h0, 32'hBFC00380);
    check_commit("int_ov");
    run_redirect("int_ov", 1, 0);

    // Instruction TLB refill, EXL clear -> refill vector
    fire(32'h400, 32'h00400000, 32'hDEAD0000, 0, 0, 32'h0,
         K_EXC, 5'd2, 32'h00400000, 1, 32'h00400000, 32'hBFC00200);
    check_commit("itlbr_exl0");
    run_redirect("itlbr_exl0", 0, 0);

    // Same with EXL set -> general vector
    fire(32'h400, 32'h00400000, 32'hDEAD0000, 0, 1, 32'h0,
         K_EXC, 5'd2, 32'h00400000, 1, 32'h00400000, 32'hBFC00380);
    check_commit("itlbr_exl1");
    run_redirect("itlbr_exl1", 0, 0);

    // eret
    fire(32'h10, 32'h80005000, 32'h0, 0, 0, 32'h80002000,
         K_ERET, 5'd0, 32'h0, 0, 32'h0, 32'h80002000);
    check_commit("eret");
    run_redirect("eret", 0, 0);

    // refetch
    fire(32'h80000000, 32'h80004000, 32'h0, 0, 0, 32'h80002000,
         K_REF, 5'd0, 32'h0, 0, 32'h0, 32'h80004000);
    check_commit("refetch");
    run_redirect("refetch", 0, 0);

    // eret outranks refetch
    fire(32'h80000010, 32'h80008000, 32'h0, 0, 0, 32'h80007000,
         K_ERET, 5'd0, 32'h0, 0, 32'h0, 32'h80007000);
    check_commit("eret_ref");
    run_redirect("eret_ref", 0, 0);

    // CpU outranks RI
    fire(32'h00060020, 32'h80009000, 32'h0, 0, 0, 32'h0,
         K_EXC, 5'd11, 32'h80009000, 0, 32'h0, 32'hBFC00380);
    check_commit("cpu_ri");
    run_redirect("cpu_ri", 0, 0);

    // Data TLB refill on store, data-side BadVAddr
    fire(32'h2000, 32'h80006000, 32'h7FFF0010, 0, 0, 32'h0,
         K_EXC, 5'd3, 32'h80006000, 1, 32'h7FFF0010, 32'hBFC00200);
    check_commit("dtlbs");
    run_redirect("dtlbs", 0, 0);

    // AdES in delay slot, fetch stalls 4 cycles, stray valid while busy
    fire(32'h200, 32'h80003004, 32'h12345678, 1, 0, 32'h0,
         K_EXC, 5'd5, 32'h80003000, 1, 32'h12345678, 32'hBFC00380);
    check_commit("ades");
    run_redirect("ades", 4, 1);

    // Reset in the middle of REDIRECT
    fire(32'h4, 32'h8000A000, 32'h0, 0, 0, 32'h0,
         K_EXC, 5'd8, 32'h8000A000, 0, 32'h0, 32'hBFC00380);
    check_commit("rst_mid");
    redirect_ready_i = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_rv_before", redirect_valid_o, 1);
    #2 resetn = 1'b0;
    #1;
    chk_all_zero("rst_mid_async");
    @(posedge clk); #1;
    resetn = 1'b1;
    redirect_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_rv", redirect_valid_o, 0);
      chk("post_rst_busy", busy_o, 0);
    end
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
